// File: rtl/max_pool2d.sv
// max_pool2d: streaming 2x2 / stride-2 signed max pooling over a raster pixel stream,
//   CH_NUM channels in lockstep; half-width line buffer holds the top-row pair maxima.
// Latency: dout_vld pulses 1 cycle after the bottom-right pixel of each 2x2 block.
// Backpressure: none; one pixel per cycle accepted, gaps in din_vld allowed anywhere.
// Ports: clk, reset_n (async active-low); frame_h/frame_w geometry (static during a frame);
//   frame_start arms a frame (pixel on the same cycle is row 0, col 0); din_vld/din input;
//   dout_vld/dout pooled pixel (held while dout_vld=0); frame_done with the last pooled pixel.
// Option: define MAX_POOL2D_RELU_EN to clamp negative pooled results to zero.
module max_pool2d #(
  parameter int FRAME_H_MAX = 224,
  parameter int FRAME_W_MAX = 224,
  parameter int DIN_WIDTH   = 8,
  parameter int CH_NUM      = 1,
  localparam int HW = $clog2(FRAME_H_MAX) + 1,
  localparam int WW = $clog2(FRAME_W_MAX) + 1
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [HW-1:0]                      frame_h,
  input  logic [WW-1:0]                      frame_w,
  input  logic                               frame_start,
  input  logic                               din_vld,
  input  logic [CH_NUM-1:0][DIN_WIDTH-1:0]   din,
  output logic                               dout_vld,
  output logic [CH_NUM-1:0][DIN_WIDTH-1:0]   dout,
  output logic                               frame_done
);

  localparam int LB_DEPTH = (FRAME_W_MAX / 2 > 1) ? FRAME_W_MAX / 2 : 2;
  localparam int LB_AW    = $clog2(LB_DEPTH);

  typedef logic [CH_NUM-1:0][DIN_WIDTH-1:0] pix_t;
  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t          state;
  logic [WW-1:0]   col;
  logic [HW-1:0]   row;
  logic [WW-1:0]   cur_col;
  logic [HW-1:0]   cur_row;
  logic [WW:0]     col_nx;
  logic [HW:0]     row_nx;
  logic            acc;
  logic            last_col;
  logic            last_row;
  logic            emit;
  logic            done_hit;
  logic [LB_AW-1:0] lb_idx;
  pix_t            prev;
  pix_t            hmax;
  pix_t            rd_dat;
  pix_t            res;
  pix_t            lb_mem [LB_DEPTH];

  function automatic logic [DIN_WIDTH-1:0] smax(input logic [DIN_WIDTH-1:0] a,
                                                input logic [DIN_WIDTH-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  always_comb begin
    // A frame_start pixel is always (0,0), whatever the counters hold.
    cur_col  = frame_start ? '0 : col;
    cur_row  = frame_start ? '0 : row;
    acc      = din_vld && (frame_start || (state == ACTIVE));
    col_nx   = {1'b0, cur_col} + {{WW{1'b0}}, 1'b1};
    row_nx   = {1'b0, cur_row} + {{HW{1'b0}}, 1'b1};
    // >= rather than == so a zero-sized geometry still terminates.
    last_col = col_nx >= {1'b0, frame_w};
    last_row = row_nx >= {1'b0, frame_h};
    // Odd/odd position is the bottom-right of a complete block; a trailing odd
    // row or column never lands on an odd index, so it drops out for free.
    emit     = acc && cur_row[0] && cur_col[0];
    done_hit = (col_nx == {1'b0, frame_w[WW-1:1], 1'b0}) &&
               (row_nx == {1'b0, frame_h[HW-1:1], 1'b0});
    lb_idx   = LB_AW'(cur_col >> 1);
    hmax     = '0;
    res      = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      hmax[c] = smax(prev[c], din[c]);
      res[c]  = smax(rd_dat[c], hmax[c]);
`ifdef MAX_POOL2D_RELU_EN
      if (res[c][DIN_WIDTH-1]) res[c] = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      dout_vld   <= 1'b0;
      dout       <= '0;
      frame_done <= 1'b0;
    end else begin
      dout_vld   <= emit;
      frame_done <= emit && done_hit;
      if (emit) dout <= res;
      if (frame_start) begin
        state <= ACTIVE;
        col   <= '0;
        row   <= '0;
      end
      // Placed after the frame_start restart so a pixel on the start cycle advances it.
      if (acc) begin
        if (last_col) begin
          col <= '0;
          if (last_row) begin
            row   <= '0;
            state <= IDLE;
          end else begin
            row <= row_nx[HW-1:0];
          end
        end else begin
          col <= col_nx[WW-1:0];
        end
      end
    end
  end

  // Datapath storage carries no reset; contents before first write are don't-care.
  always_ff @(posedge clk) begin
    if (acc) prev <= din;
    if (acc && !cur_row[0] && cur_col[0]) lb_mem[lb_idx] <= hmax;
    // Read on the even column of the odd row; data waits here for the odd column.
    if (acc && cur_row[0] && !cur_col[0]) rd_dat <= lb_mem[lb_idx];
  end

endmodule

// File: tb/tb_max_pool2d.sv
module tb_max_pool2d;
  localparam int DW = 8;
  localparam int CH = 2;

  logic                    clk = 1'b0;
  logic                    reset_n = 1'b1;
  logic [8:0]              frame_h = 9'd4;
  logic [8:0]              frame_w = 9'd4;
  logic                    frame_start = 1'b0;
  logic                    din_vld = 1'b0;
  logic [CH-1:0][DW-1:0]   din = '0;
  logic                    dout_vld;
  logic [CH-1:0][DW-1:0]   dout;
  logic                    frame_done;

  max_pool2d #(.FRAME_H_MAX(224), .FRAME_W_MAX(224), .DIN_WIDTH(DW), .CH_NUM(CH)) dut (
    .clk(clk), .reset_n(reset_n), .frame_h(frame_h), .frame_w(frame_w),
    .frame_start(frame_start), .din_vld(din_vld), .din(din),
    .dout_vld(dout_vld), .dout(dout), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output capture: value, frame_done flag and cycle stamp of every dout_vld pulse.
  logic [CH-1:0][DW-1:0] oq[$];
  bit                    dq[$];
  int                    sq[$];
  always @(negedge clk) begin
    if (dout_vld === 1'b1) begin
      oq.push_back(dout);
      dq.push_back(frame_done);
      sq.push_back(cyc);
    end
  end

  int errors = 0;
  int checks = 0;
  int st[16];

  task automatic clear_q();
    oq.delete(); dq.delete(); sq.delete();
  endtask

  task automatic px(input logic vld, input logic fs, input int c0, input int c1, output int stamp);
    @(negedge clk);
    din_vld = vld; frame_start = fs;
    din[0] = 8'(c0); din[1] = 8'(c1);
    stamp = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      din_vld = 1'b0; frame_start = 1'b0;
    end
  endtask

  // Full 4x4 frame, ch0 = index, ch1 = 15-index, 'gap' idle cycles after each pixel.
  task automatic drive_4x4(input int gap);
    for (int i = 0; i < 16; i++) begin
      px(1'b1, i == 0, i, 15 - i, st[i]);
      if (gap > 0) idle(gap);
    end
    idle(3);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (dout_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got %b want 0", dout_vld); end
    checks++; if (dout !== '0) begin errors++; $display("FAIL reset_dout got %h want 0", dout); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", frame_done); end
    @(negedge clk); reset_n = 1'b1;
    idle(2);
  endtask

  task automatic test_basic();
    int ev[4] = '{5, 7, 13, 15};
    frame_h = 9'd4; frame_w = 9'd4;
    clear_q();
    drive_4x4(0);
    checks++; if (oq.size() !== 4) begin errors++; $display("FAIL basic_count got %0d want 4", oq.size()); end
    for (int k = 0; k < 4 && k < oq.size(); k++) begin
      checks++; if (oq[k][0] !== 8'(ev[k])) begin errors++; $display("FAIL basic_val%0d got %0d want %0d", k, oq[k][0], ev[k]); end
      checks++; if (sq[k] !== st[ev[k]] + 1) begin errors++; $display("FAIL basic_lat%0d got cyc %0d want %0d", k, sq[k], st[ev[k]] + 1); end
      checks++; if (dq[k] !== (k == 3)) begin errors++; $display("FAIL basic_done%0d got %b want %b", k, dq[k], k == 3); end
    end
  endtask

  task automatic test_odd_geometry();
    int s;
    frame_h = 9'd5; frame_w = 9'd3;
    clear_q();
    for (int i = 0; i < 15; i++) px(1'b1, i == 0, i, 0, st[i]);
    idle(3);
    checks++; if (oq.size() !== 2) begin errors++; $display("FAIL odd_count got %0d want 2", oq.size()); end
    if (oq.size() >= 2) begin
      checks++; if (oq[0][0] !== 8'd4) begin errors++; $display("FAIL odd_val0 got %0d want 4", oq[0][0]); end
      checks++; if (oq[1][0] !== 8'd10) begin errors++; $display("FAIL odd_val1 got %0d want 10", oq[1][0]); end
      checks++; if (sq[1] !== st[10] + 1) begin errors++; $display("FAIL odd_lat1 got cyc %0d want %0d", sq[1], st[10] + 1); end
      checks++; if (dq[0] !== 1'b0 || dq[1] !== 1'b1) begin errors++; $display("FAIL odd_done got %b%b want 01", dq[0], dq[1]); end
    end
    // Back in IDLE: pixels without frame_start must be ignored.
    for (int i = 0; i < 8; i++) px(1'b1, 1'b0, 100, 100, s);
    idle(3);
    checks++; if (oq.size() !== 2) begin errors++; $display("FAIL odd_idle got %0d outputs want 2", oq.size()); end
  endtask

  task automatic test_negative();
    int s;
    logic [DW-1:0] exp0;
`ifdef MAX_POOL2D_RELU_EN
    exp0 = 8'h00;
`else
    exp0 = 8'hFF;
`endif
    frame_h = 9'd2; frame_w = 9'd2;
    clear_q();
    px(1'b1, 1'b1, -3, 5, s);
    px(1'b1, 1'b0, -7, 6, s);
    px(1'b1, 1'b0, -1, 7, s);
    px(1'b1, 1'b0, -128, 8, s);
    idle(3);
    checks++; if (oq.size() !== 1) begin errors++; $display("FAIL neg_count got %0d want 1", oq.size()); end
    if (oq.size() >= 1) begin
      checks++; if (oq[0][0] !== exp0) begin errors++; $display("FAIL neg_ch0 got %h want %h", oq[0][0], exp0); end
      checks++; if (oq[0][1] !== 8'd8) begin errors++; $display("FAIL neg_ch1 got %0d want 8", oq[0][1]); end
      checks++; if (dq[0] !== 1'b1) begin errors++; $display("FAIL neg_done got %b want 1", dq[0]); end
    end
  endtask

  task automatic test_gaps_2ch();
    int ev[4] = '{5, 7, 13, 15};
    int e1[4] = '{15, 13, 7, 5};
    frame_h = 9'd4; frame_w = 9'd4;
    clear_q();
    drive_4x4(3);
    checks++; if (oq.size() !== 4) begin errors++; $display("FAIL gap_count got %0d want 4", oq.size()); end
    for (int k = 0; k < 4 && k < oq.size(); k++) begin
      checks++; if (oq[k][0] !== 8'(ev[k])) begin errors++; $display("FAIL gap_ch0_%0d got %0d want %0d", k, oq[k][0], ev[k]); end
      checks++; if (oq[k][1] !== 8'(e1[k])) begin errors++; $display("FAIL gap_ch1_%0d got %0d want %0d", k, oq[k][1], e1[k]); end
      checks++; if (sq[k] !== st[ev[k]] + 1) begin errors++; $display("FAIL gap_lat%0d got cyc %0d want %0d", k, sq[k], st[ev[k]] + 1); end
      checks++; if (dq[k] !== (k == 3)) begin errors++; $display("FAIL gap_done%0d got %b want %b", k, dq[k], k == 3); end
    end
  endtask

  task automatic test_abort();
    int ev[4] = '{5, 7, 13, 15};
    int s;
    // Aborted frame is 8 wide, so its 6 pixels stay in row 0 and complete no block.
    frame_h = 9'd4; frame_w = 9'd8;
    clear_q();
    for (int i = 0; i < 6; i++) px(1'b1, i == 0, 90 + i, 90 + i, s);
    idle(1);
    frame_w = 9'd4;
    drive_4x4(0);
    checks++; if (oq.size() !== 4) begin errors++; $display("FAIL abort_count got %0d want 4", oq.size()); end
    for (int k = 0; k < 4 && k < oq.size(); k++) begin
      checks++; if (oq[k][0] !== 8'(ev[k])) begin errors++; $display("FAIL abort_val%0d got %0d want %0d", k, oq[k][0], ev[k]); end
    end
    if (oq.size() >= 4) begin
      checks++; if (dq[3] !== 1'b1) begin errors++; $display("FAIL abort_done got %b want 1", dq[3]); end
    end
  endtask

  task automatic test_reset_mid();
    int s;
    frame_h = 9'd4; frame_w = 9'd4;
    for (int i = 0; i < 6; i++) px(1'b1, i == 0, i, 0, s);
    @(negedge clk);
    din_vld = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checks++; if (dout_vld !== 1'b0) begin errors++; $display("FAIL rstmid_vld got %b want 0", dout_vld); end
    checks++; if (dout !== '0) begin errors++; $display("FAIL rstmid_dout got %h want 0", dout); end
    @(negedge clk); reset_n = 1'b1;
    clear_q();
    for (int i = 0; i < 16; i++) px(1'b1, 1'b0, i, 0, s);
    idle(3);
    checks++; if (oq.size() !== 0) begin errors++; $display("FAIL rstmid_nostart got %0d outputs want 0", oq.size()); end
    drive_4x4(0);
    checks++; if (oq.size() !== 4) begin errors++; $display("FAIL rstmid_count got %0d want 4", oq.size()); end
    if (oq.size() >= 4) begin
      checks++; if (oq[3][0] !== 8'd15) begin errors++; $display("FAIL rstmid_last got %0d want 15", oq[3][0]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_odd_geometry();
    test_negative();
    test_gaps_2ch();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
